etapa_id: RTL and testbench
===========================

# etapa_id

Instruction-decode pipeline stage of the MIPS32 datapath, sitting directly upstream of the register file and feeding the execute stage. Takes the fetched instruction, drives the register-file read addresses, captures the returned operands, and decodes control, immediate and destination. Everything lands in a one-cycle ID/EX pipeline register with stall and flush control.

## Interface
- S_AD, 5, register-address width
- S_DATA, 32, data/instruction width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- if_valid  in  1  instr/pc_plus4 hold a real instruction
- instr  in  S_DATA  fetched instruction
- pc_plus4  in  S_DATA  PC+4 of instr
- stall  in  1  hazard unit: hold ID/EX contents
- flush  in  1  branch/jump taken: insert bubble
- ARead1 / ARead2  out  S_AD  register-file read addresses (instr[25:21] / instr[20:16]), combinational
- DRead1 / DRead2  in  S_DATA  register-file read data
- wb_we, wb_addr, wb_data  in  1 / S_AD / S_DATA  write-back port, same signals that feed register-file WE/AWR/DataIn
- ex_valid  out  1  ID/EX holds a live instruction
- ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm  out  S_DATA  registered operands; ex_imm is the sign-extended or zero-extended imm16
- ex_rs, ex_rt, ex_dest  out  S_AD  source indices and selected destination
- ex_funct  out  6  instr[5:0]
- ex_jtarget  out  S_DATA  {pc_plus4[31:28], instr[25:0], 2'b00}
- ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch, ex_jump  out  1 each  control
- ex_alu_op  out  2  00 add, 01 sub, 10 R-type by funct, 11 immediate logic/compare (with ex_imm_op)
- ex_imm_op  out  2  00 and, 01 or, 10 slt
- ex_illegal  out  1  unsupported opcode was decoded

## Operation
- Supported opcodes:
  - 0x00 R-type: dest=rd, reg_write, alu_op=10
  - 0x08 addi: sign-extend, alu_src, reg_write, alu_op=00, dest=rt
  - 0x0C andi / 0x0D ori: zero-extend, alu_op=11, imm_op 00/01, dest=rt
  - 0x0A slti: sign-extend, alu_op=11, imm_op=10
  - 0x23 lw: mem_read, mem_to_reg, alu_src, reg_write, dest=rt
  - 0x2B sw: mem_write, alu_src, no reg_write
  - 0x04 beq: branch, alu_op=01
  - 0x02 j: jump
- Any other opcode: all controls 0, ex_illegal=1, ex_valid follows if_valid.
- reg_write forced 0 whenever the selected dest is 0 ($zero never written).
- if_valid=0: capture a bubble (ex_valid=0, all controls 0); data fields are don't-care but still captured.
- Operand capture: ex_rs_data=DRead1, ex_rt_data=DRead2, subject to Configuration.

## Timing
- Latency 1: fields decoded in cycle N appear on ex_* after edge N+1.
- Priority at each edge: rst > flush > stall > normal capture.
- rst: every ex_* output, including data fields, becomes 0.
- flush: ex_valid, all controls and ex_illegal become 0; data fields are don't-care. flush with stall both high still yields a bubble.
- stall (no flush): every ex_* register holds its value. ARead1/2 keep following instr; the upstream stage holds instr.
- Reset mid-stall: reset wins; outputs zero next cycle.

## Configuration
- WB_BYPASS_EN defined: if wb_we and wb_addr≠0 and wb_addr==ARead1 (resp. ARead2), capture wb_data instead of DRead1 (resp. DRead2). Both operands bypass independently.
- Not defined: DRead1/DRead2 are captured unconditionally. The write-back stage must then write in the first half-cycle.

## Structure
- Shared package mips_pkg: opcode and funct localparams, alu_op/imm_op encodings, and a control-bundle struct (reg_write…jump, alu_op, imm_op, illegal).
- Sub-module decodificador_control: purely combinational opcode→control bundle plus the extension select. etapa_id instantiates it and owns the ID/EX register, dest mux and bypass.

## Test plan
- rst=1 for 2 cycles with instr=0x20080005 and if_valid=1 → all ex_* are 0; the next edge yields ex_valid=1, ex_imm=0x00000005, ex_dest=8, ex_alu_src=1, ex_reg_write=1.
- instr=0x01095020 (add $10,$8,$9), DRead1=7, DRead2=9 → ARead1=8, ARead2=9; next cycle ex_rs_data=7, ex_rt_data=9, ex_dest=10, ex_alu_op=10, ex_funct=0x20.
- instr=0xAD09FFFC (sw) → ex_imm=0xFFFFFFFC, ex_mem_write=1, ex_reg_write=0. Then instr=0x3508FFFF (ori) → ex_imm=0x0000FFFF, ex_imm_op=01.
- stall=1 for 3 cycles while instr changes → ex_* frozen. Then flush=1 together with stall=1 → ex_valid=0 and controls 0 next cycle.
- instr=0x08000010 with pc_plus4=0x90000004 → ex_jump=1, ex_jtarget=0x90000040. Then instr=0xFC000000 → ex_illegal=1, all controls 0.
- With WB_BYPASS_EN: wb_we=1, wb_addr=8, wb_data=0x1234, DRead1=0 during add $10,$8,$9 → ex_rs_data=0x1234. With wb_addr=0 → ex_rs_data=DRead1. Without the macro → ex_rs_data=DRead1 in both cases.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS32 opcode/funct constants, ALU encodings and the decode control bundle
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [1:0] IMM_AND = 2'b00;
    localparam logic [1:0] IMM_OR  = 2'b01;
    localparam logic [1:0] IMM_SLT = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
        logic [1:0] imm_op;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // andi/ori take a zero-extended immediate, everything else sign-extends
    function automatic logic [31:0] ext_imm16(input logic [15:0] imm, input logic zero_ext);
        return zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/decodificador_control.sv
// rtl/decodificador_control.sv - combinational opcode to control-bundle decoder
module decodificador_control
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl,
    output logic       zero_ext,
    output logic       reg_dst
);

    always_comb begin
        ctrl     = CTRL_NOP;
        zero_ext = 1'b0;
        reg_dst  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
                reg_dst        = 1'b1;
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            OP_ANDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_IMM;
                ctrl.imm_op    = IMM_AND;
                zero_ext       = 1'b1;
            end
            OP_ORI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_IMM;
                ctrl.imm_op    = IMM_OR;
                zero_ext       = 1'b1;
            end
            OP_SLTI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_IMM;
                ctrl.imm_op    = IMM_SLT;
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/etapa_id.sv
// rtl/etapa_id.sv - MIPS32 decode stage with ID/EX register; WB_BYPASS_EN enables write-back operand bypass
module etapa_id
    import mips_pkg::*;
#(
    parameter int S_AD   = 5,
    parameter int S_DATA = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [S_DATA-1:0] instr,
    input  logic [S_DATA-1:0] pc_plus4,
    input  logic              stall,
    input  logic              flush,
    output logic [S_AD-1:0]   ARead1,
    output logic [S_AD-1:0]   ARead2,
    input  logic [S_DATA-1:0] DRead1,
    input  logic [S_DATA-1:0] DRead2,
    input  logic              wb_we,
    input  logic [S_AD-1:0]   wb_addr,
    input  logic [S_DATA-1:0] wb_data,
    output logic              ex_valid,
    output logic [S_DATA-1:0] ex_pc_plus4,
    output logic [S_DATA-1:0] ex_rs_data,
    output logic [S_DATA-1:0] ex_rt_data,
    output logic [S_DATA-1:0] ex_imm,
    output logic [S_AD-1:0]   ex_rs,
    output logic [S_AD-1:0]   ex_rt,
    output logic [S_AD-1:0]   ex_dest,
    output logic [5:0]        ex_funct,
    output logic [S_DATA-1:0] ex_jtarget,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic [1:0]        ex_alu_op,
    output logic [1:0]        ex_imm_op,
    output logic              ex_illegal
);

    ctrl_t             dec_ctrl;
    ctrl_t             ctrl_next;
    ctrl_t             ex_ctrl;
    logic              zero_ext;
    logic              reg_dst;
    logic [S_AD-1:0]   dest_next;
    logic [S_DATA-1:0] imm_next;
    logic [S_DATA-1:0] jtarget_next;
    logic [S_DATA-1:0] rs_data_next;
    logic [S_DATA-1:0] rt_data_next;

    decodificador_control u_decodificador_control (
        .opcode   (instr[31:26]),
        .ctrl     (dec_ctrl),
        .zero_ext (zero_ext),
        .reg_dst  (reg_dst)
    );

    assign ARead1 = instr[25:21];
    assign ARead2 = instr[20:16];

    assign dest_next    = reg_dst ? instr[15:11] : instr[20:16];
    assign imm_next     = ext_imm16(instr[15:0], zero_ext);
    assign jtarget_next = {pc_plus4[S_DATA-1:S_DATA-4], instr[25:0], 2'b00};

    // $zero is never written, and a non-instruction decodes to a bubble
    always_comb begin
        ctrl_next = dec_ctrl;
        if (dest_next == '0) begin
            ctrl_next.reg_write = 1'b0;
        end
        if (!if_valid) begin
            ctrl_next = CTRL_NOP;
        end
    end

`ifdef WB_BYPASS_EN
    // a same-cycle write-back to a source register overrides the stale file read
    always_comb begin
        rs_data_next = DRead1;
        rt_data_next = DRead2;
        if (wb_we && (wb_addr != '0) && (wb_addr == ARead1)) begin
            rs_data_next = wb_data;
        end
        if (wb_we && (wb_addr != '0) && (wb_addr == ARead2)) begin
            rt_data_next = wb_data;
        end
    end
`else
    logic unused_wb;
    assign unused_wb    = ^{wb_we, wb_addr, wb_data};
    assign rs_data_next = DRead1;
    assign rt_data_next = DRead2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= CTRL_NOP;
            ex_pc_plus4 <= '0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_dest     <= '0;
            ex_funct    <= '0;
            ex_jtarget  <= '0;
        end else if (flush || !stall) begin
            ex_valid    <= if_valid && !flush;
            ex_ctrl     <= flush ? CTRL_NOP : ctrl_next;
            ex_pc_plus4 <= pc_plus4;
            ex_rs_data  <= rs_data_next;
            ex_rt_data  <= rt_data_next;
            ex_imm      <= imm_next;
            ex_rs       <= instr[25:21];
            ex_rt       <= instr[20:16];
            ex_dest     <= dest_next;
            ex_funct    <= instr[5:0];
            ex_jtarget  <= jtarget_next;
        end
    end

    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_branch     = ex_ctrl.branch;
    assign ex_jump       = ex_ctrl.jump;
    assign ex_alu_op     = ex_ctrl.alu_op;
    assign ex_imm_op     = ex_ctrl.imm_op;
    assign ex_illegal    = ex_ctrl.illegal;

endmodule

// File: tb/tb_etapa_id.sv
// tb/tb_etapa_id.sv - scoreboard bench for etapa_id with directed vectors
module tb_etapa_id;

    typedef struct packed {
        logic       valid;
        logic       rw;
        logic       m2r;
        logic       mr;
        logic       mw;
        logic       asrc;
        logic       br;
        logic       jmp;
        logic [1:0] aop;
        logic [1:0] iop;
        logic       ill;
    } ctl_t;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [31:0] jt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [5:0]  funct;
    } dat_t;

    typedef struct {
        int    tag;
        string name;
        ctl_t  c;
        dat_t  d;
        logic  chk_d;
        logic  chk_id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, if_valid, stall, flush, wb_we;
    logic [31:0] instr, pc_plus4, DRead1, DRead2, wb_data;
    logic [4:0]  wb_addr, ARead1, ARead2;
    logic        ex_valid;
    logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm, ex_jtarget;
    logic [4:0]  ex_rs, ex_rt, ex_dest;
    logic [5:0]  ex_funct;
    logic        ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
    logic        ex_alu_src, ex_branch, ex_jump, ex_illegal;
    logic [1:0]  ex_alu_op, ex_imm_op;

    etapa_id dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .instr(instr), .pc_plus4(pc_plus4),
        .stall(stall), .flush(flush), .ARead1(ARead1), .ARead2(ARead2),
        .DRead1(DRead1), .DRead2(DRead2), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_dest(ex_dest), .ex_funct(ex_funct), .ex_jtarget(ex_jtarget),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_alu_op(ex_alu_op), .ex_imm_op(ex_imm_op), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    exp_t q[$];
    exp_t mon_e;
    ctl_t act_c;
    dat_t act_d;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic ctl_t mk_c(input logic v, rw, m2r, mr, mw, asrc, br, jmp,
                                  input logic [1:0] aop, iop, input logic ill);
        return '{v, rw, m2r, mr, mw, asrc, br, jmp, aop, iop, ill};
    endfunction

    function automatic dat_t mk_d(input logic [31:0] pc4, rsd, rtd, imm, jt,
                                  input logic [4:0] rs, rt, dest, input logic [5:0] funct);
        return '{pc4, rsd, rtd, imm, jt, rs, rt, dest, funct};
    endfunction

    // monitor: compares the oldest pending expectation once its cycle arrives
    always begin
        @(posedge clk);
        #2;
        if (q.size() > 0 && q[0].tag == cyc) begin
            mon_e = q.pop_front();
            act_c = '{ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
                      ex_alu_src, ex_branch, ex_jump, ex_alu_op, ex_imm_op, ex_illegal};
            act_d = '{ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm, ex_jtarget,
                      ex_rs, ex_rt, ex_dest, ex_funct};
            chk({mon_e.name, "_ctl"}, 256'(act_c), 256'(mon_e.c));
            if (mon_e.chk_d) chk({mon_e.name, "_data"}, 256'(act_d), 256'(mon_e.d));
            else if (mon_e.chk_id) chk({mon_e.name, "_imm_dest"}, {ex_imm, ex_dest},
                                       {mon_e.d.imm, mon_e.d.dest});
        end
    end

    task automatic step(input string name, input logic r, v, s, f,
                        input logic [31:0] ins, pc, d1, d2,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input ctl_t c, input dat_t d, input logic chk_d, input logic chk_id);
        exp_t e;
        @(negedge clk);
        rst = r; if_valid = v; stall = s; flush = f;
        instr = ins; pc_plus4 = pc; DRead1 = d1; DRead2 = d2;
        wb_we = we; wb_addr = wa; wb_data = wd;
        #1;
        chk({name, "_aread1"}, 256'(ARead1), 256'(ins[25:21]));
        chk({name, "_aread2"}, 256'(ARead2), 256'(ins[20:16]));
        e.tag = cyc + 1; e.name = name; e.c = c; e.d = d; e.chk_d = chk_d; e.chk_id = chk_id;
        q.push_back(e);
    endtask

    ctl_t c0, c_addi, c_add, c_ori;
    dat_t d0, d_ori, d_byp_rs, d_byp_rt;
    logic [31:0] byp_rs, byp_rt;

    initial begin
        rst = 1'b1; if_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        instr = 32'h20080005; pc_plus4 = 32'h00400004; DRead1 = 32'h11; DRead2 = 32'h22;
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
        c0     = '0;
        d0     = '0;
        c_addi = mk_c(1, 1, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0);
        c_add  = mk_c(1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0);
        c_ori  = mk_c(1, 1, 0, 0, 0, 1, 0, 0, 2'b11, 2'b01, 0);
        d_ori  = mk_d(32'h00400010, 32'hC, 32'hD, 32'h0000FFFF, 32'h0423FFFC, 5'd8, 5'd8, 5'd8, 6'h3F);
`ifdef WB_BYPASS_EN
        byp_rs = 32'h1234;
        byp_rt = 32'hABCD;
`else
        byp_rs = 32'h0;
        byp_rt = 32'h0;
`endif
        d_byp_rs = mk_d(32'h00400020, byp_rs, 32'h9, 32'h00005020, 32'h04254080, 5'd8, 5'd9, 5'd10, 6'h20);
        d_byp_rt = mk_d(32'h00400028, 32'h7, byp_rt, 32'h00005020, 32'h04254080, 5'd8, 5'd9, 5'd10, 6'h20);

        step("rst0", 1, 1, 0, 0, 32'h20080005, 32'h00400004, 32'h11, 32'h22, 0, 0, 0, c0, d0, 1, 0);
        step("rst1", 1, 1, 0, 0, 32'h20080005, 32'h00400004, 32'h11, 32'h22, 0, 0, 0, c0, d0, 1, 0);
        step("addi", 0, 1, 0, 0, 32'h20080005, 32'h00400004, 32'h11, 32'h22, 0, 0, 0, c_addi,
             mk_d(32'h00400004, 32'h11, 32'h22, 32'h5, 32'h00200014, 5'd0, 5'd8, 5'd8, 6'h05), 1, 0);
        step("add", 0, 1, 0, 0, 32'h01095020, 32'h00400008, 32'h7, 32'h9, 0, 0, 0, c_add,
             mk_d(32'h00400008, 32'h7, 32'h9, 32'h00005020, 32'h04254080, 5'd8, 5'd9, 5'd10, 6'h20), 1, 0);
        step("sw", 0, 1, 0, 0, 32'hAD09FFFC, 32'h0040000C, 32'hA, 32'hB, 0, 0, 0,
             mk_c(1, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0),
             mk_d(32'h0040000C, 32'hA, 32'hB, 32'hFFFFFFFC, 32'h0427FFF0, 5'd8, 5'd9, 5'd9, 6'h3C), 1, 0);
        step("ori", 0, 1, 0, 0, 32'h3508FFFF, 32'h00400010, 32'hC, 32'hD, 0, 0, 0, c_ori, d_ori, 1, 0);
        step("stall0", 0, 1, 1, 0, 32'h11090003, 32'h00400014, 32'h1, 32'h2, 0, 0, 0, c_ori, d_ori, 1, 0);
        step("stall1", 0, 1, 1, 0, 32'h8D090004, 32'h00400018, 32'h3, 32'h4, 0, 0, 0, c_ori, d_ori, 1, 0);
        step("stall2", 0, 1, 1, 0, 32'h20000001, 32'h0040001C, 32'h5, 32'h6, 0, 0, 0, c_ori, d_ori, 1, 0);
        step("flush_stall", 0, 1, 1, 1, 32'h01095020, 32'h00400020, 32'h7, 32'h9, 0, 0, 0, c0, d0, 0, 0);
        step("jump", 0, 1, 0, 0, 32'h08000010, 32'h90000004, 32'h5, 32'h6, 0, 0, 0,
             mk_c(1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0),
             mk_d(32'h90000004, 32'h5, 32'h6, 32'h00000010, 32'h90000040, 5'd0, 5'd0, 5'd0, 6'h10), 1, 0);
        step("illegal", 0, 1, 0, 0, 32'hFC000000, 32'h90000008, 32'h0, 32'h0, 0, 0, 0,
             mk_c(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1), d0, 0, 0);
        step("bubble", 0, 0, 0, 0, 32'h01095020, 32'h9000000C, 32'h7, 32'h9, 0, 0, 0, c0, d0, 0, 0);
        step("beq", 0, 1, 0, 0, 32'h11090003, 32'h00400010, 32'h7, 32'h9, 0, 0, 0,
             mk_c(1, 0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 0), d0, 0, 0);
        step("lw", 0, 1, 0, 0, 32'h8D090004, 32'h00400014, 32'h7, 32'h9, 0, 0, 0,
             mk_c(1, 1, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0),
             mk_d(0, 0, 0, 32'h00000004, 0, 0, 0, 5'd9, 0), 0, 1);
        step("slti", 0, 1, 0, 0, 32'h2908FFFF, 32'h00400018, 32'h7, 32'h9, 0, 0, 0,
             mk_c(1, 1, 0, 0, 0, 1, 0, 0, 2'b11, 2'b10, 0),
             mk_d(0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 5'd8, 0), 0, 1);
        step("andi", 0, 1, 0, 0, 32'h3108000F, 32'h0040001C, 32'h7, 32'h9, 0, 0, 0,
             mk_c(1, 1, 0, 0, 0, 1, 0, 0, 2'b11, 2'b00, 0),
             mk_d(0, 0, 0, 32'h0000000F, 0, 0, 0, 5'd8, 0), 0, 1);
        step("addi_zero", 0, 1, 0, 0, 32'h20000001, 32'h00400020, 32'h7, 32'h9, 0, 0, 0,
             mk_c(1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0),
             mk_d(0, 0, 0, 32'h00000001, 0, 0, 0, 5'd0, 0), 0, 1);
        step("rtype_zero", 0, 1, 0, 0, 32'h01090020, 32'h00400024, 32'h7, 32'h9, 0, 0, 0,
             mk_c(1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0),
             mk_d(0, 0, 0, 32'h00000020, 0, 0, 0, 5'd0, 0), 0, 1);
        step("bypass_rs", 0, 1, 0, 0, 32'h01095020, 32'h00400020, 32'h0, 32'h9, 1, 5'd8, 32'h1234,
             c_add, d_byp_rs, 1, 0);
        step("bypass_zero", 0, 1, 0, 0, 32'h20080005, 32'h00400024, 32'h55, 32'h66, 1, 5'd0, 32'h1234,
             c_addi, mk_d(32'h00400024, 32'h55, 32'h66, 32'h5, 32'h00200014, 5'd0, 5'd8, 5'd8, 6'h05), 1, 0);
        step("bypass_rt", 0, 1, 0, 0, 32'h01095020, 32'h00400028, 32'h7, 32'h0, 1, 5'd9, 32'hABCD,
             c_add, d_byp_rt, 1, 0);
        step("hold", 0, 1, 1, 0, 32'hAD09FFFC, 32'h0040002C, 32'h1, 32'h2, 0, 0, 0, c_add, d_byp_rt, 1, 0);
        step("rst_stall", 1, 1, 1, 0, 32'hAD09FFFC, 32'h0040002C, 32'h1, 32'h2, 0, 0, 0, c0, d0, 1, 0);
        step("idle", 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, c0, d0, 0, 0);

        repeat (4) @(negedge clk);
        chk("drain", 256'(q.size()), 256'(0));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
